// File: rtl/usb_endp_in_fifo.sv
// ---------------------------------------------------------------------------
// usb_endp_in_fifo: USB IN endpoint byte FIFO; bytes are held until ACK, rewind on NAK.
// Optional flush port when ENDP_FIFO_FLUSH_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_endp_in_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [WIDTH-1:0]      sie_q,
  input  logic                  sie_rdreq,
  output logic                  sie_empty,
  input  logic                  sie_ack,
`ifdef ENDP_FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  sie_rewind
);

  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]    mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_tent;
  logic [DEPTH_LOG2:0] rd_commit;

  logic                flush_req;
  logic                do_write;
  logic                do_read;
  logic [DEPTH_LOG2:0] rd_tent_adv;

`ifdef ENDP_FIFO_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign level     = wr_ptr - rd_commit;
  assign full      = (level == DEPTH);
  assign sie_empty = (wr_ptr == rd_tent);
  assign sie_q     = mem[rd_tent[DEPTH_LOG2-1:0]];

  // Full is judged on pre-ack pointers, so an ack never admits a same-cycle write.
  assign do_write    = wrreq && !full && !flush_req;
  assign do_read     = sie_rdreq && !sie_empty && !sie_rewind;
  assign rd_tent_adv = rd_tent + {{DEPTH_LOG2{1'b0}}, do_read};

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_tent   <= '0;
      rd_commit <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (wrreq && full && !flush_req) begin
        overflow <= 1'b1;
      end

      if (flush_req) begin
        rd_tent   <= wr_ptr;
        rd_commit <= wr_ptr;
      end else if (sie_rewind) begin
        rd_tent <= rd_commit;
      end else begin
        rd_tent <= rd_tent_adv;
        if (sie_ack) begin
          rd_commit <= rd_tent_adv;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_endp_in_fifo.sv
// ---------------------------------------------------------------------------
// tb_usb_endp_in_fifo: directed stimulus against a queue-based FIFO model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_usb_endp_in_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = '0;
  logic       wrreq = 1'b0;
  logic       full;
  logic [6:0] level;
  logic       overflow;
  logic [7:0] sie_q;
  logic       sie_rdreq = 1'b0;
  logic       sie_empty;
  logic       sie_ack = 1'b0;
  logic       sie_rewind = 1'b0;
  logic       flush_tb = 1'b0;

  int checks = 0;
  int errors = 0;

  usb_endp_in_fifo #(.DEPTH_LOG2(6), .WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .wrreq      (wrreq),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .sie_q      (sie_q),
    .sie_rdreq  (sie_rdreq),
    .sie_empty  (sie_empty),
    .sie_ack    (sie_ack),
`ifdef ENDP_FIFO_FLUSH_EN
    .flush      (flush_tb),
`endif
    .sie_rewind (sie_rewind)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue holds every byte from the commit point; nread counts bytes read but not acked.
  logic [7:0] q[$];
  int         nread = 0;
  bit         m_ovf = 1'b0;
  bit         was_full, was_empty;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      nread = 0;
      m_ovf = 1'b0;
    end else begin
      was_full  = (q.size() == 64);
      was_empty = (nread == q.size());
      if (flush_tb) begin
        q.delete();
        nread = 0;
      end else begin
        if (sie_rewind) begin
          nread = 0;
        end else begin
          if (sie_rdreq && !was_empty) nread++;
          if (sie_ack) begin
            repeat (nread) void'(q.pop_front());
            nread = 0;
          end
        end
        if (wrreq) begin
          if (was_full) m_ovf = 1'b1;
          else q.push_back(data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("m_full", {31'd0, full}, {31'd0, q.size() == 64});
      chk("m_level", {25'd0, level}, q.size());
      chk("m_empty", {31'd0, sie_empty}, {31'd0, nread == q.size()});
      chk("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
      if (nread < q.size()) chk("m_sie_q", {24'd0, sie_q}, {24'd0, q[nread]});
    end
  end

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit a, input bit rw);
    wrreq = w; data = d; sie_rdreq = r; sie_ack = a; sie_rewind = rw;
    @(posedge clk);
    #1;
    wrreq = 1'b0; sie_rdreq = 1'b0; sie_ack = 1'b0; sie_rewind = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, sie_empty}, 32'd1);
    chk("rst_level", {25'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_level", {25'd0, level}, 32'd0);

    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    chk("first_q", {24'd0, sie_q}, 32'h11);
    chk("first_level", {25'd0, level}, 32'd2);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 1, 0);
    chk("drain_level", {25'd0, level}, 32'd0);

    for (int i = 0; i < 8; i++) step(1, 8'hA0 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("pkt_q", {24'd0, sie_q}, 32'hA0 + i);
      step(0, 8'h00, 1, 0, 0);
    end
    chk("pkt_empty", {31'd0, sie_empty}, 32'd1);
    step(0, 8'h00, 0, 0, 1);
    chk("rew_q", {24'd0, sie_q}, 32'hA0);
    chk("rew_empty", {31'd0, sie_empty}, 32'd0);
    chk("rew_level", {25'd0, level}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("resend_q", {24'd0, sie_q}, 32'hA0 + i);
      step(0, 8'h00, 1, i == 7, 0);
    end
    chk("ack_level", {25'd0, level}, 32'd0);
    chk("ack_empty", {31'd0, sie_empty}, 32'd1);

    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("pre_full", {31'd0, full}, 32'd0);
      step(1, 8'h40 + 8'(i), 0, 0, 0);
    end
    chk("full_64", {31'd0, full}, 32'd1);
    step(1, 8'hFF, 0, 0, 0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_level", {25'd0, level}, 32'd64);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'hEE, 0, 1, 0);
    chk("ack_wr_level", {25'd0, level}, 32'd63);
    for (int i = 1; i < 64; i++) begin
      chk("full_rd_q", {24'd0, sie_q}, 32'h40 + i);
      step(0, 8'h00, 1, i == 63, 0);
    end
    chk("full_drained", {25'd0, level}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 8; i++) step(1, 8'(p * 8 + i), 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
        chk("wrap_q", {24'd0, sie_q}, p * 8 + i);
        step(0, 8'h00, 1, i == 7, 0);
      end
    end
    chk("wrap_level", {25'd0, level}, 32'd0);

    for (int i = 0; i < 10; i++) step(1, 8'hB0 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    chk("pre_rew_q", {24'd0, sie_q}, 32'hB4);
    step(0, 8'h00, 1, 1, 1);
    chk("prio_q", {24'd0, sie_q}, 32'hB0);
    chk("prio_level", {25'd0, level}, 32'd10);
    step(0, 8'h00, 0, 1, 0);
    chk("prio_noncommit", {25'd0, level}, 32'd10);

`ifdef ENDP_FIFO_FLUSH_EN
    flush_tb = 1'b1;
    step(1, 8'h99, 0, 0, 0);
    flush_tb = 1'b0;
    chk("flush_level", {25'd0, level}, 32'd0);
    chk("flush_empty", {31'd0, sie_empty}, 32'd1);
`else
    for (int i = 0; i < 10; i++) step(0, 8'h00, 1, i == 9, 0);
    chk("final_level", {25'd0, level}, 32'd0);
    chk("final_empty", {31'd0, sie_empty}, 32'd1);
`endif
    step(0, 8'h00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_endp_in_fifo.md
Name: usb_endp_in_fifo

Overview:
- Byte FIFO for one USB IN endpoint, with retransmission support.
- CPU side is written through the shared I/O bus by the ENDPIx_DATA store path (data/wrreq/full).
- SIE side is drained by the USB transmit engine while it builds a DATA packet.
- Bytes stay in the FIFO until the host ACKs the packet, so a NAK'd or timed-out packet can be rewound and resent.

Parameters:
- DEPTH_LOG2, 6: FIFO depth is 2**DEPTH_LOG2 bytes (default 64).
- WIDTH, 8: data width in bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data  input  WIDTH  CPU write data.
- wrreq  input  1  CPU write strobe; one byte per cycle.
- full  output  1  no committed space left.
- level  output  DEPTH_LOG2+1  bytes held, including read-but-unacknowledged bytes.
- overflow  output  1  sticky: a write was attempted while full.
- sie_q  output  WIDTH  byte at the tentative read pointer (show-ahead).
- sie_rdreq  input  1  advance the tentative read pointer.
- sie_empty  output  1  no unread bytes for the SIE.
- sie_ack  input  1  host ACKed; commit all bytes read so far.
- sie_rewind  input  1  NAK/timeout; return the tentative pointer to the commit point.

Behaviour:
- State: wr_ptr, rd_tent and rd_commit, each DEPTH_LOG2+1 bits and wrapping modulo 2**(DEPTH_LOG2+1). Memory is a register array indexed by the low DEPTH_LOG2 bits.
- Reset (reset=0, asynchronous):
  - all pointers = 0, overflow = 0;
  - outputs: full = 0, sie_empty = 1, level = 0, sie_q = memory at index 0 (contents undefined);
  - memory contents are not reset.
- Combinational status:
  - full = (wr_ptr - rd_commit) == 2**DEPTH_LOG2
  - level = wr_ptr - rd_commit
  - sie_empty = (wr_ptr == rd_tent)
  - sie_q = mem[rd_tent], zero-cycle show-ahead, valid whenever sie_empty=0
- Write: if wrreq && !full, mem[wr_ptr] <= data and wr_ptr++.
  - If wrreq && full: data is dropped, wr_ptr is unchanged, overflow <= 1. overflow clears only on reset.
- Read: if sie_rdreq && !sie_empty && !sie_rewind, rd_tent++. sie_rdreq while empty is ignored.
- Ack: if sie_ack && !sie_rewind, rd_commit <= rd_tent (the value after any same-cycle rdreq increment), freeing space from the next cycle.
- Rewind: if sie_rewind, rd_tent <= rd_commit. sie_rdreq and sie_ack in the same cycle are ignored (rewind has priority).
- Simultaneous-event rules:
  - A write and an ack in the same cycle: full is evaluated on pre-ack pointers, so a write on a full FIFO is dropped even if an ack frees space that cycle.
  - A write to the slot at rd_tent in the same cycle it is read: impossible, since full blocks it.
  - A write while sie_empty=1: sie_empty falls and sie_q shows the new byte on the next cycle.
- Wrap-around: pointers roll over naturally; full/empty stay correct across wrap because of the extra MSB.
- Reset mid-packet: all read/committed state is discarded; the SIE must treat the FIFO as empty.
- No other internal state machine. Latency: write to visible on sie_q = 1 cycle; ack to full deasserting = 1 cycle.

Optional Feature:
- Macro ENDP_FIFO_FLUSH_EN.
- Defined: adds input port flush (1 bit, synchronous). When flush=1, all three pointers are set to wr_ptr, discarding every byte.
  - flush takes priority over rdreq, ack and rewind.
  - A wrreq in the same cycle is dropped and does not set overflow.
- Undefined: no flush port; the FIFO empties only by SIE reads plus ack.

Test Plan:
- Reset → full=0, sie_empty=1, level=0, overflow=0; then write 0x11, 0x22 → next cycle sie_q=0x11, level=2.
- Write 0xA0..0xA7; rdreq x8 reading 0xA0..0xA7; sie_rewind → sie_q=0xA0, sie_empty=0, level=8.
- Same 8 bytes read again, then sie_ack → level=0, sie_empty=1; 64 further writes → full=1 exactly after the 64th.
- FIFO full; write 0xFF → overflow=1, level=64, 0xFF never appears on sie_q. sie_ack in the same cycle as a write on full → write still dropped.
- Wrap test: 200 bytes counting 0x00..0xC7 streamed in 8-byte packets with interleaved acks → SIE sees every value in order, no loss; level never exceeds 64.
- sie_rewind, sie_ack and sie_rdreq asserted together after 4 bytes were read → rd_tent returns to the commit point, nothing committed, level unchanged. With ENDP_FIFO_FLUSH_EN, flush with 10 bytes held → level=0, sie_empty=1 next cycle.
